// File: rtl/mdu_iter_if.sv
// Handshake/bus bundle for the iterative multiply/divide unit.
//   master: pipeline side, drives start/op/a/b/flush and observes status/results
//   slave : the unit itself (mdu_iter)
// Signals:
//   start, op[1:0], a, b, flush        -> request side
//   busy, done, result_lo, result_hi,
//   div_by_zero                        <- status/result side
interface mdu_iter_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit for the EX stage.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : mdu_iter_if.slave
//          start/op/a/b sampled while not busy (IDLE or DONE)
//          op: 00 MULU, 01 MULS, 10 DIVU, 11 DIVS
//          flush aborts to IDLE without a done pulse
//          busy high in RUN and FIX, done pulses in DONE
//          {result_hi,result_lo} = product, or {remainder,quotient}
//          div_by_zero flags a divide with b==0
// Signed operations run on magnitudes; the recorded signs are applied in FIX.
module mdu_iter #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  mdu_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic               is_div_reg;
  logic               neg_lo_reg;   // negate product / quotient in FIX
  logic               neg_hi_reg;   // negate remainder in FIX
  logic [WIDTH-1:0]   mcand_reg;    // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_reg;      // MUL: {hi,lo} accumulator; DIV: low half is dividend/quotient
  logic [WIDTH-1:0]   rem_reg;      // DIV partial remainder
  logic [WIDTH-1:0]   lo_reg, hi_reg;
  logic               dbz_reg;

  logic               accept;
  logic               div_zero;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    accept   = bus.start && !bus.flush && (state_reg == IDLE || state_reg == DONE);
    div_zero = bus.op[1] && (bus.b == '0);
    // The most-negative value negates to itself and is then read as unsigned.
    abs_a    = (bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b    = (bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Shift-add: add multiplicand to the upper half when the current
    // multiplier bit (acc LSB) is set; the carry lands in the top bit.
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);

    // Restoring divide: the borrow bit of the trial subtraction decides the quotient bit.
    div_shift = {rem_reg, acc_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_reg};
    div_ge    = ~div_diff[WIDTH];

    prod_fix = neg_lo_reg ? -acc_reg : acc_reg;
    quo_fix  = neg_lo_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem_fix  = neg_hi_reg ? -rem_reg : rem_reg;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (accept)                  state_next = div_zero ? DONE : RUN;
        else if (state_reg == DONE)  state_next = IDLE;
      end
      RUN:     if (cnt_reg == CW'(1)) state_next = FIX;
      FIX:     state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      is_div_reg <= 1'b0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      mcand_reg  <= '0;
      acc_reg    <= '0;
      rem_reg    <= '0;
      lo_reg     <= '0;
      hi_reg     <= '0;
      dbz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        is_div_reg <= bus.op[1];
        neg_lo_reg <= bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        neg_hi_reg <= bus.op[0] & bus.op[1] & bus.a[WIDTH-1];
        mcand_reg  <= bus.op[1] ? abs_b : abs_a;
        acc_reg    <= {{WIDTH{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
        rem_reg    <= '0;
        cnt_reg    <= CW'(WIDTH);
        dbz_reg    <= div_zero;
        // Divide by zero completes immediately with fixed results.
        if (div_zero) begin
          lo_reg <= '1;
          hi_reg <= bus.a;
        end
      end else if (state_reg == RUN && !bus.flush) begin
        cnt_reg <= cnt_reg - CW'(1);
        if (is_div_reg) begin
          rem_reg <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          acc_reg <= {{WIDTH{1'b0}}, acc_reg[WIDTH-2:0], div_ge};
        end else begin
          acc_reg <= {mul_sum, acc_reg[WIDTH-1:1]};
        end
      end else if (state_reg == FIX && !bus.flush) begin
        if (is_div_reg) begin
          lo_reg <= quo_fix;
          hi_reg <= rem_fix;
        end else begin
          lo_reg <= prod_fix[WIDTH-1:0];
          hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

  assign bus.busy        = (state_reg == RUN) || (state_reg == FIX);
  assign bus.done        = (state_reg == DONE);
  assign bus.result_lo   = lo_reg;
  assign bus.result_hi   = hi_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases plus randomized operations
// on a WIDTH=16 instance, and a WIDTH=8 instance for the narrow-width case.
// Expected results come from an integer-arithmetic reference model.
module tb_mdu_iter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(16)) i16 ();
  mdu_iter_if #(.WIDTH(8))  i8 ();

  mdu_iter #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(i16));
  mdu_iter #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(i8));

  int n_vec = 0;
  int n_err = 0;

  // Last visible results of the 16-bit instance, as the model sees them.
  longint m_lo = 0, m_hi = 0, m_dz = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on sign-interpreted operands.
  function automatic void ref_op(input int w, input logic [1:0] op, input longint a, input longint b,
                                 output longint lo, output longint hi, output longint dz);
    longint mask, sa, sb, p, q, r;
    mask = (longint'(1) << w) - 1;
    sa = a[w-1] ? a - (longint'(1) << w) : a;
    sb = b[w-1] ? b - (longint'(1) << w) : b;
    dz = 0;
    if (!op[1]) begin
      p  = op[0] ? sa * sb : a * b;
      lo = p & mask;
      hi = (p >> w) & mask;
    end else if (b == 0) begin
      lo = mask; hi = a; dz = 1;
    end else begin
      q  = op[0] ? sa / sb : a / b;
      r  = op[0] ? sa % sb : a % b;
      lo = q & mask;
      hi = r & mask;
    end
  endfunction

  // After an abort: no done for n cycles, nothing busy, results unchanged.
  task automatic expect_quiet(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("quiet_done", i16.done, 0);
    end
    check("quiet_busy", i16.busy, 0);
    check("quiet_lo", i16.result_lo, m_lo);
    check("quiet_hi", i16.result_hi, m_hi);
    check("quiet_dz", i16.div_by_zero, m_dz);
  endtask

  // Runs one operation on the 16-bit unit. Returns positioned in the done
  // cycle (or idle after an abort), so a following call starts back-to-back.
  task automatic run16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int flush_at, input int junk_at, input int rst_at);
    longint e_lo, e_hi, e_dz;
    int lat;
    ref_op(16, op, a, b, e_lo, e_hi, e_dz);
    lat = (e_dz != 0) ? 1 : 18;
    i16.op = op; i16.a = a; i16.b = b; i16.start = 1'b1;
    step();
    i16.start = 1'b0;
    if (e_dz != 0) begin
      m_lo = e_lo; m_hi = e_hi; m_dz = 1;
    end else begin
      m_dz = 0;
    end
    for (int k = 1; k <= lat; k++) begin
      if (k == rst_at && k < lat) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_busy", i16.busy, 0);
        check("rst_done", i16.done, 0);
        check("rst_lo", i16.result_lo, 0);
        check("rst_hi", i16.result_hi, 0);
        check("rst_dz", i16.div_by_zero, 0);
        m_lo = 0; m_hi = 0; m_dz = 0;
        expect_quiet(20);
        $display("op=%0d a=%h b=%h reset at T+%0d", op, a, b, k);
        return;
      end
      if (k == flush_at && k < lat) begin
        i16.flush = 1'b1;
        step();
        i16.flush = 1'b0;
        check("flush_busy", i16.busy, 0);
        expect_quiet(20);
        $display("op=%0d a=%h b=%h flushed at T+%0d", op, a, b, k);
        return;
      end
      if (k == junk_at && k < lat) begin
        i16.start = 1'b1; i16.a = 16'h0002; i16.b = 16'h0002;
      end
      check("busy", i16.busy, (e_dz == 0 && k <= 17) ? 1 : 0);
      check("done", i16.done, (k == lat) ? 1 : 0);
      if (k == lat) begin
        check("lo", i16.result_lo, e_lo);
        check("hi", i16.result_hi, e_hi);
        check("dz", i16.div_by_zero, e_dz);
        m_lo = e_lo; m_hi = e_hi; m_dz = e_dz;
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d", op, a, b, i16.result_hi, i16.result_lo, i16.div_by_zero);
      end else begin
        step();
        i16.start = 1'b0;
      end
    end
  endtask

  task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    longint e_lo, e_hi, e_dz;
    int lat;
    ref_op(8, op, a, b, e_lo, e_hi, e_dz);
    lat = (e_dz != 0) ? 1 : 10;
    i8.op = op; i8.a = a; i8.b = b; i8.start = 1'b1;
    step();
    i8.start = 1'b0;
    for (int k = 1; k < lat; k++) begin
      check("w8_done_early", i8.done, 0);
      step();
    end
    check("w8_done", i8.done, 1);
    check("w8_lo", i8.result_lo, e_lo);
    check("w8_hi", i8.result_hi, e_hi);
    check("w8_dz", i8.div_by_zero, e_dz);
    $display("w8 op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d", op, a, b, i8.result_hi, i8.result_lo, i8.div_by_zero);
    step();
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [15:0] r_a, r_b;
    int fl, jk, gap;
    rst = 1'b1;
    i16.start = 1'b0; i16.op = '0; i16.a = '0; i16.b = '0; i16.flush = 1'b0;
    i8.start  = 1'b0; i8.op  = '0; i8.a  = '0; i8.b  = '0; i8.flush  = 1'b0;
    step();
    step();
    check("reset_busy", i16.busy, 0);
    check("reset_done", i16.done, 0);
    check("reset_lo", i16.result_lo, 0);
    check("reset_hi", i16.result_hi, 0);
    check("reset_dz", i16.div_by_zero, 0);
    rst = 1'b0;
    step();

    run16(2'b00, 16'hFFFF, 16'hFFFF, 0, 0, 0);
    step();
    run16(2'b01, 16'hFFFD, 16'h0007, 0, 0, 0);
    run16(2'b11, 16'hFFF9, 16'h0002, 0, 0, 0);   // back-to-back from done cycle
    step();
    check("done_clears", i16.done, 0);
    run16(2'b10, 16'h0064, 16'h0000, 0, 0, 0);
    run16(2'b10, 16'h0064, 16'h0007, 0, 0, 0);
    step();
    run16(2'b11, 16'h8000, 16'hFFFF, 0, 0, 0);
    step();
    run16(2'b01, 16'h8000, 16'h8000, 0, 0, 0);
    step();
    run16(2'b00, 16'h0003, 16'h0005, 5, 0, 0);   // flushed, results keep prior values
    run16(2'b00, 16'h1234, 16'h0056, 0, 3, 0);   // start during busy ignored
    step();
    run16(2'b11, 16'h9ABC, 16'h0123, 0, 0, 8);   // reset mid-divide
    run16(2'b11, 16'h7FFF, 16'h8000, 0, 0, 0);
    step();

    for (int n = 0; n < 40; n++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = 16'($urandom);
      r_b  = 16'($urandom);
      case ($urandom_range(0, 9))
        0: r_b = 16'h0000;
        1: begin r_a = 16'h8000; r_b = 16'hFFFF; end
        2: r_b = 16'h0001;
        default: ;
      endcase
      fl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 17)) : 0;
      jk = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 16)) : 0;
      run16(r_op, r_a, r_b, fl, jk, 0);
      if (fl == 0) begin
        gap = int'($urandom_range(0, 2));
        if (gap > 0) begin
          step();
          check("gap_done", i16.done, 0);
          check("gap_busy", i16.busy, 0);
          for (int g = 1; g < gap; g++) step();
        end
      end
    end

    run8(2'b00, 8'hFF, 8'hFF);
    for (int n = 0; n < 8; n++) begin
      run8(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the EX stage of the pipelined CPU. Adds MUL/DIV support that the single-cycle ALU lacks.
- Parametrised in operand width, with signed and unsigned modes.
- The hazard logic holds the pipeline while busy is high. Results return as a HI/LO pair to the write-back path.
- Radix-2 datapath: one product or quotient bit per cycle.

Parameters:
WIDTH, 16, operand width in bits (>=4); the product is 2*WIDTH bits.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only while not busy
op  input  2  00 MULU, 01 MULS, 10 DIVU, 11 DIVS; sampled with start
a  input  WIDTH  multiplicand / dividend; sampled with start
b  input  WIDTH  multiplier / divisor; sampled with start
flush  input  1  abort from branch or if_flush logic
busy  output  1  operation in progress; drives the pipeline stall
done  output  1  one-cycle pulse; results valid
result_lo  output  WIDTH  product low half, or quotient
result_hi  output  WIDTH  product high half, or remainder
div_by_zero  output  1  set with done when a divide had b==0

Behaviour:
- States: IDLE, RUN, FIX, DONE.
- Reset (rst=1 at an edge):
  - state=IDLE, iteration counter=0.
  - busy, done, div_by_zero, result_lo and result_hi all 0.
  - Reset takes priority over every other input, including mid-operation. No done follows.
- Accept: start=1 at edge T while state is IDLE or DONE, and flush=0.
  - Latch op, a and b.
  - Signed ops operate on magnitudes: |x| is computed in WIDTH bits, so the most-negative value maps to itself, read as unsigned.
  - Record the result sign:
    - MULS: sign(a) XOR sign(b).
    - DIVS quotient: sign(a) XOR sign(b).
    - DIVS remainder: sign(a).
  - Counter loads WIDTH. Next state is RUN, unless it is a divide with b==0 (see below).
- RUN (cycles T+1 .. T+WIDTH): one iteration per cycle, counter decrements, leave when the counter reaches 0.
  - MUL: shift-add over a 2*WIDTH accumulator.
  - DIV: restoring shift-subtract, with a WIDTH+1-bit partial remainder.
- FIX (cycle T+WIDTH+1): two's-complement negate the product, quotient and/or remainder as the recorded signs require. Unsigned ops pass through unchanged.
- DONE (cycle T+WIDTH+2):
  - done=1 for exactly this cycle.
  - result_lo/result_hi are registered and hold until the next accepted start or rst.
  - A new start is accepted in this cycle (back-to-back). Otherwise the next state is IDLE.
- Latency summary:
  - busy=1 from T+1 through T+WIDTH+1 (RUN and FIX), 0 in IDLE and DONE.
  - done appears WIDTH+2 cycles after the accept edge.
- Result mapping:
  - MUL: {result_hi,result_lo} = full 2*WIDTH product.
  - DIV: result_lo = quotient truncated toward zero; result_hi = remainder, carrying the sign of the dividend.
- Divide by zero (DIVU or DIVS with b==0):
  - No RUN or FIX; next state is DONE, so done is at T+1 and busy never rises.
  - result_lo = all ones, result_hi = a unchanged, div_by_zero=1.
  - div_by_zero is cleared on the next accept.
- Signed overflow: DIVS of most-negative by -1 gives result_lo = most-negative, result_hi = 0. No flag is raised.
- start while busy: ignored. Latched operands and the op are unaffected.
- flush=1 in any state:
  - Next state is IDLE; busy falls the following cycle; no done is produced.
  - result_lo, result_hi and div_by_zero keep their previous values.
  - flush and start in the same cycle: flush wins and start is dropped.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- WIDTH=16, rst held 2 cycles, then MULU a=0xFFFF b=0xFFFF at T -> busy T+1..T+17; done at T+18 only; hi=0xFFFE, lo=0x0001.
- MULS a=0xFFFD(-3) b=0x0007 -> hi=0xFFFF, lo=0xFFEB (-21). Back-to-back DIVS a=0xFFF9(-7) b=0x0002 started in the done cycle -> lo=0xFFFD, hi=0xFFFF, done 18 cycles later.
- DIVU a=0x0064 b=0x0000 -> done at T+1, busy stays 0, lo=0xFFFF, hi=0x0064, div_by_zero=1. Next DIVU 100/7 -> lo=0x000E, hi=0x0002, div_by_zero=0.
- DIVS a=0x8000 b=0xFFFF -> lo=0x8000, hi=0x0000. MULS a=0x8000 b=0x8000 -> hi=0x4000, lo=0x0000.
- MULU 3*5 started, flush at T+5 -> busy 0 at T+6, no done ever, results keep prior values. start with a=2, b=2 at T+3 of a later op -> ignored.
- rst asserted at T+8 of a divide -> all outputs 0 next cycle, no done. WIDTH=8 instance: MULU 0xFF*0xFF -> hi=0xFE, lo=0x01, done at T+10.
